// File: rtl/posit_denormalize_pipe.sv
// Two-stage elastic posit decoder: splits a posit word into sign, NaR/zero flags,
// signed scale and MSB-aligned fraction, with rts/rtr handshake and a passthrough tag.
module posit_denormalize_pipe #(
    parameter int POSIT_WIDTH = 16,
    parameter int POSIT_ES    = 1,
    parameter int TAG_WIDTH   = 1,
    localparam int SCALE_W    = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
    localparam int FRAC_W     = POSIT_WIDTH - POSIT_ES - 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [POSIT_WIDTH-1:0]    posit_word_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic                      rts_i,
    output logic                      rtr_o,
    output logic                      sign,
    output logic                      inf,
    output logic                      zero,
    output logic signed [SCALE_W-1:0] scale,
    output logic [FRAC_W-1:0]         fraction,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic                      rts_o,
    input  logic                      rtr_i
);
    localparam int N  = POSIT_WIDTH;
    localparam int MW = $clog2(N);
    localparam int TW = N - 3;

    logic v1, v2;
    logic s1_adv, s2_adv;

    assign s2_adv = !v2 || rtr_i;
    assign s1_adv = !v1 || s2_adv;
    assign rtr_o  = s1_adv;
    assign rts_o  = v2;

    // Stage 1 front end: magnitude of the body and length of the regime run.
    // The low n-1 bits of -word depend only on the low n-1 bits of word.
    logic          in_sign, in_zero, in_inf, in_r;
    logic [N-2:0]  in_body;
    logic [MW-1:0] in_run;

    assign in_sign = posit_word_i[N-1];
    assign in_body = in_sign ? -posit_word_i[N-2:0] : posit_word_i[N-2:0];
    assign in_zero = (posit_word_i == '0);
    assign in_inf  = in_sign && (posit_word_i[N-2:0] == '0);
    assign in_r    = in_body[N-2];

    // NOTE: combinational blocks use blocking '=' so later loop iterations see
    // earlier results; the default before the loop keeps this free of latches.
    always_comb begin
        in_run = MW'(N - 1);
        for (int i = 0; i <= N - 3; i++) begin
            if (in_body[i] != in_r) in_run = MW'(N - 2 - i);
        end
    end

    logic                 s1_sign, s1_zero, s1_inf, s1_r;
    logic [MW-1:0]        s1_run;
    logic [TW-1:0]        s1_tail;
    logic [TAG_WIDTH-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (s1_adv) begin
            v1 <= rts_i;
        end
    end

    // NOTE: payload registers are not reset; v1 alone says whether they hold a
    // live word, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (s1_adv && rts_i) begin
            s1_sign <= in_sign;
            s1_zero <= in_zero;
            s1_inf  <= in_inf;
            s1_r    <= in_r;
            s1_run  <= in_run;
            s1_tail <= in_body[N-4:0];
            s1_tag  <= tag_i;
        end
    end

    // Stage 2: drop regime run + terminator; the tail starts right after bit n-3,
    // so shifting by run-1 left-aligns exponent and fraction.
    logic [TW-1:0]              rest;
    logic signed [SCALE_W-1:0]  run_s, k_val, scale_val;
    logic [FRAC_W-1:0]          frac_val;

    assign rest     = s1_tail << (s1_run - MW'(1));
    assign run_s    = $signed(SCALE_W'(s1_run));
    assign k_val    = s1_r ? (run_s - SCALE_W'(1)) : (SCALE_W'(0) - run_s);
    assign frac_val = rest[FRAC_W-1:0];

    if (POSIT_ES > 0) begin : g_exp
        logic [POSIT_ES-1:0] e_val;
        assign e_val     = rest[TW-1 -: POSIT_ES];
        assign scale_val = (k_val <<< POSIT_ES) + $signed(SCALE_W'(e_val));
    end else begin : g_noexp
        assign scale_val = k_val;
    end

    logic s1_special;
    assign s1_special = s1_zero || s1_inf;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            sign     <= 1'b0;
            inf      <= 1'b0;
            zero     <= 1'b0;
            scale    <= '0;
            fraction <= '0;
            tag_o    <= '0;
        end else if (s2_adv) begin
            v2 <= v1;
            if (v1) begin
                sign     <= s1_sign;
                inf      <= s1_inf;
                zero     <= s1_zero;
                scale    <= s1_special ? '0 : scale_val;
                fraction <= s1_special ? '0 : frac_val;
                tag_o    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_posit_denormalize_pipe.sv
// Bench for posit_denormalize_pipe: directed tables (16/1, 16/0), backpressure and
// mid-stream reset on 16/1, and randomized scoreboarding on 8/0 and 32/2.
module tb_posit_denormalize_pipe;

    typedef struct {
        logic        sign;
        logic        inf;
        logic        zero;
        longint      scale;
        logic [63:0] frac;
    } dec_t;

    typedef struct {
        logic [63:0] word;
        dec_t        d;
    } vec_t;

    typedef struct {
        logic [7:0] tag;
        dec_t       d;
    } item_t;

    int n_vec = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit, ES=1
    logic [15:0]       a_word;
    logic [7:0]        a_tag_i, a_tag_o;
    logic              a_rts_i, a_rtr_o, a_sign, a_inf, a_zero, a_rts_o, a_rtr_i;
    logic signed [5:0] a_scale;
    logic [11:0]       a_frac;
    // 16-bit, ES=0
    logic [15:0]       b_word;
    logic [7:0]        b_tag_i, b_tag_o;
    logic              b_rts_i, b_rtr_o, b_sign, b_inf, b_zero, b_rts_o, b_rtr_i;
    logic signed [4:0] b_scale;
    logic [12:0]       b_frac;
    // random pair shares handshake inputs
    logic              r_rts, r_rtr;
    logic [7:0]        c_word, c_tag_i, c_tag_o;
    logic              c_rtr_o, c_sign, c_inf, c_zero, c_rts_o;
    logic signed [3:0] c_scale;
    logic [4:0]        c_frac;
    logic [31:0]       d_word;
    logic [7:0]        d_tag_i, d_tag_o;
    logic              d_rtr_o, d_sign, d_inf, d_zero, d_rts_o;
    logic signed [7:0] d_scale;
    logic [26:0]       d_frac;

    posit_denormalize_pipe #(.POSIT_WIDTH(16), .POSIT_ES(1), .TAG_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .posit_word_i(a_word), .tag_i(a_tag_i), .rts_i(a_rts_i),
        .rtr_o(a_rtr_o), .sign(a_sign), .inf(a_inf), .zero(a_zero), .scale(a_scale),
        .fraction(a_frac), .tag_o(a_tag_o), .rts_o(a_rts_o), .rtr_i(a_rtr_i));

    posit_denormalize_pipe #(.POSIT_WIDTH(16), .POSIT_ES(0), .TAG_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .posit_word_i(b_word), .tag_i(b_tag_i), .rts_i(b_rts_i),
        .rtr_o(b_rtr_o), .sign(b_sign), .inf(b_inf), .zero(b_zero), .scale(b_scale),
        .fraction(b_frac), .tag_o(b_tag_o), .rts_o(b_rts_o), .rtr_i(b_rtr_i));

    posit_denormalize_pipe #(.POSIT_WIDTH(8), .POSIT_ES(0), .TAG_WIDTH(8)) u_c (
        .clk(clk), .rst(rst), .posit_word_i(c_word), .tag_i(c_tag_i), .rts_i(r_rts),
        .rtr_o(c_rtr_o), .sign(c_sign), .inf(c_inf), .zero(c_zero), .scale(c_scale),
        .fraction(c_frac), .tag_o(c_tag_o), .rts_o(c_rts_o), .rtr_i(r_rtr));

    posit_denormalize_pipe #(.POSIT_WIDTH(32), .POSIT_ES(2), .TAG_WIDTH(8)) u_d (
        .clk(clk), .rst(rst), .posit_word_i(d_word), .tag_i(d_tag_i), .rts_i(r_rts),
        .rtr_o(d_rtr_o), .sign(d_sign), .inf(d_inf), .zero(d_zero), .scale(d_scale),
        .fraction(d_frac), .tag_o(d_tag_o), .rts_o(d_rts_o), .rtr_i(r_rtr));

    // Reference decoder: walks the bit string the way the posit format is defined.
    function automatic dec_t ref_decode(input logic [63:0] w_in, input int n, input int es);
        dec_t        d;
        logic [63:0] mask, w, a;
        logic        r;
        int          run, pos;
        longint      k, e, f;
        mask    = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        w       = w_in & mask;
        d.sign  = w[n-1];
        d.inf   = 1'b0;
        d.zero  = 1'b0;
        d.scale = 0;
        d.frac  = '0;
        if (w == 64'd0) begin
            d.zero = 1'b1;
            return d;
        end
        if (w == (64'd1 << (n - 1))) begin
            d.inf = 1'b1;
            return d;
        end
        a   = d.sign ? ((~w + 64'd1) & mask) : w;
        r   = a[n-2];
        run = 0;
        while (run < n - 1 && a[n-2-run] == r) run++;
        k   = r ? longint'(run - 1) : -longint'(run);
        pos = n - 3 - run;
        e   = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((pos >= 0) ? longint'(a[pos]) : 64'sd0);
            pos--;
        end
        f = 0;
        for (int j = 0; j < n - es - 3; j++) begin
            f = f * 2 + ((pos >= 0) ? longint'(a[pos]) : 64'sd0);
            pos--;
        end
        d.scale = k * (longint'(1) << es) + e;
        d.frac  = 64'(f);
        return d;
    endfunction

    function automatic logic [63:0] pick_word(input int n);
        logic [63:0] mask;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        case ($urandom_range(15))
            0:       return 64'd0;
            1:       return 64'd1 << (n - 1);
            2:       return mask >> 1;
            3:       return 64'd1;
            4:       return mask;
            default: return {$urandom(), $urandom()} & mask;
        endcase
    endfunction

    function automatic vec_t mk(input logic [63:0] w, input logic s, input logic i,
                                input logic z, input longint sc, input logic [63:0] f);
        vec_t v;
        v.word    = w;
        v.d.sign  = s;
        v.d.inf   = i;
        v.d.zero  = z;
        v.d.scale = sc;
        v.d.frac  = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_dec(input string name, input dec_t exp, input logic s, input logic i,
                             input logic z, input longint sc, input logic [63:0] fr);
        check({name, ".sign"},  64'(s),  64'(exp.sign));
        check({name, ".inf"},   64'(i),  64'(exp.inf));
        check({name, ".zero"},  64'(z),  64'(exp.zero));
        check({name, ".scale"}, sc,      exp.scale);
        check({name, ".frac"},  fr,      exp.frac);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t   ta[10];
    vec_t   tz[4];
    item_t  aq[$], cq[$], dq[$];
    item_t  it;
    localparam int NW = 10000;

    initial begin
        ta[0] = mk(64'h4000, 1'b0, 1'b0, 1'b0,   0, 64'h000);
        ta[1] = mk(64'h5000, 1'b0, 1'b0, 1'b0,   1, 64'h000);
        ta[2] = mk(64'h3000, 1'b0, 1'b0, 1'b0,  -1, 64'h000);
        ta[3] = mk(64'h4800, 1'b0, 1'b0, 1'b0,   0, 64'h800);
        ta[4] = mk(64'h0000, 1'b0, 1'b0, 1'b1,   0, 64'h000);
        ta[5] = mk(64'h8000, 1'b1, 1'b1, 1'b0,   0, 64'h000);
        ta[6] = mk(64'h7FFF, 1'b0, 1'b0, 1'b0,  28, 64'h000);
        ta[7] = mk(64'h0001, 1'b0, 1'b0, 1'b0, -28, 64'h000);
        ta[8] = mk(64'hC000, 1'b1, 1'b0, 1'b0,   0, 64'h000);
        ta[9] = mk(64'h6C00, 1'b0, 1'b0, 1'b0,   3, 64'h800);
        tz[0] = mk(64'h7FFF, 1'b0, 1'b0, 1'b0,  14, 64'h0000);
        tz[1] = mk(64'h0001, 1'b0, 1'b0, 1'b0, -14, 64'h0000);
        tz[2] = mk(64'h6000, 1'b0, 1'b0, 1'b0,   1, 64'h0000);
        tz[3] = mk(64'h4001, 1'b0, 1'b0, 1'b0,   0, 64'h0001);

        a_word = '0; a_tag_i = '0; a_rts_i = 1'b0; a_rtr_i = 1'b1;
        b_word = '0; b_tag_i = '0; b_rts_i = 1'b0; b_rtr_i = 1'b1;
        c_word = '0; c_tag_i = '0; d_word = '0; d_tag_i = '0;
        r_rts  = 1'b0; r_rtr = 1'b1;
        rst    = 1'b1;
        tick;
        tick;
        rst = 1'b0;

        check("rst.rts_o", 64'(a_rts_o), 64'd0);
        check("rst.rtr_o", 64'(a_rtr_o), 64'd1);
        check("rst.tag_o", 64'(a_tag_o), 64'd0);
        check_dec("rst", mk(64'd0, 1'b0, 1'b0, 1'b0, 0, 64'd0).d, a_sign, a_inf, a_zero,
                  longint'(a_scale), 64'(a_frac));

        // Back-to-back directed streams; vector c-2 is on the outputs in iteration c.
        for (int c = 0; c < 12; c++) begin
            a_rts_i = (c < 10);
            b_rts_i = (c < 4);
            if (c < 10) begin
                a_word  = 16'(ta[c].word);
                a_tag_i = 8'(c + 1);
            end
            if (c < 4) begin
                b_word  = 16'(tz[c].word);
                b_tag_i = 8'(c + 1);
            end
            if (c < 2) begin
                check($sformatf("a.lat%0d.rts_o", c), 64'(a_rts_o), 64'd0);
            end else begin
                check($sformatf("a.vec%0d.rts_o", c - 2), 64'(a_rts_o), 64'd1);
                check($sformatf("a.vec%0d.tag", c - 2), 64'(a_tag_o), 64'(c - 1));
                check_dec($sformatf("a.vec%0d", c - 2), ta[c-2].d, a_sign, a_inf, a_zero,
                          longint'(a_scale), 64'(a_frac));
            end
            if (c >= 2 && c < 6) begin
                check($sformatf("b.vec%0d.rts_o", c - 2), 64'(b_rts_o), 64'd1);
                check_dec($sformatf("b.vec%0d", c - 2), tz[c-2].d, b_sign, b_inf, b_zero,
                          longint'(b_scale), 64'(b_frac));
            end
            tick;
        end
        check("a.drained", 64'(a_rts_o), 64'd0);
        check("b.drained", 64'(b_rts_o), 64'd0);

        // Backpressure: tags 1..6, rtr_i low for three cycles once the pipe is full.
        begin
            int sent = 0, got = 0, cyc = 0;
            while (got < 6 && cyc < 40) begin
                a_rtr_i = !(cyc >= 3 && cyc <= 5);
                a_rts_i = (sent < 6);
                if (sent < 6) begin
                    a_word  = 16'(pick_word(16));
                    a_tag_i = 8'(sent + 1);
                end
                #1;
                if (cyc >= 3 && cyc <= 5) check($sformatf("bp.rtr_o_low%0d", cyc), 64'(a_rtr_o), 64'd0);
                if (a_rts_o) begin
                    if (aq.size() == 0) begin
                        check("bp.spurious", 64'(a_rts_o), 64'd0);
                    end else begin
                        check("bp.tag", 64'(a_tag_o), 64'(aq[0].tag));
                        check_dec("bp", aq[0].d, a_sign, a_inf, a_zero, longint'(a_scale), 64'(a_frac));
                        if (a_rtr_i) begin
                            void'(aq.pop_front());
                            got++;
                        end
                    end
                end
                if (a_rts_i && a_rtr_o) begin
                    it.tag = a_tag_i;
                    it.d   = ref_decode(64'(a_word), 16, 1);
                    aq.push_back(it);
                    sent++;
                end
                tick;
                cyc++;
            end
            check("bp.received", 64'(got), 64'd6);
            a_rts_i = 1'b0;
            a_rtr_i = 1'b1;
        end

        // Reset with both stages full plus a word offered in the reset cycle.
        for (int i = 0; i < 3; i++) begin
            a_rts_i = 1'b1;
            a_word  = 16'(pick_word(16) | 64'h0100);
            a_tag_i = 8'(8'h40 + i);
            tick;
        end
        check("mid.full.rts_o", 64'(a_rts_o), 64'd1);
        check("mid.full.rtr_o", 64'(a_rtr_o), 64'd1);
        rst     = 1'b1;
        a_tag_i = 8'hEE;
        a_word  = 16'h4800;
        tick;
        rst     = 1'b0;
        a_rts_i = 1'b0;
        check("mid.rts_o", 64'(a_rts_o), 64'd0);
        check("mid.rtr_o", 64'(a_rtr_o), 64'd1);
        check("mid.tag_o", 64'(a_tag_o), 64'd0);
        check_dec("mid", mk(64'd0, 1'b0, 1'b0, 1'b0, 0, 64'd0).d, a_sign, a_inf, a_zero,
                  longint'(a_scale), 64'(a_frac));
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("mid.after%0d.rts_o", i), 64'(a_rts_o), 64'd0);
        end

        // Randomized traffic on 8/0 and 32/2 with random rts/rtr.
        begin
            int c_sent = 0, d_sent = 0, cyc = 0;
            while (!(c_sent >= NW && d_sent >= NW && cq.size() == 0 && dq.size() == 0)
                   && cyc < 60000) begin
                r_rtr   = ($urandom_range(3) != 0);
                r_rts   = ($urandom_range(3) != 0) && (c_sent < NW) && (d_sent < NW);
                c_word  = 8'(pick_word(8));
                d_word  = 32'(pick_word(32));
                c_tag_i = 8'(c_sent);
                d_tag_i = 8'(d_sent + 7);
                #1;
                if (c_rts_o) begin
                    if (cq.size() == 0) begin
                        check("c.spurious", 64'(c_rts_o), 64'd0);
                    end else begin
                        check("c.tag", 64'(c_tag_o), 64'(cq[0].tag));
                        check_dec("c", cq[0].d, c_sign, c_inf, c_zero, longint'(c_scale), 64'(c_frac));
                        if (r_rtr) void'(cq.pop_front());
                    end
                end
                if (d_rts_o) begin
                    if (dq.size() == 0) begin
                        check("d.spurious", 64'(d_rts_o), 64'd0);
                    end else begin
                        check("d.tag", 64'(d_tag_o), 64'(dq[0].tag));
                        check_dec("d", dq[0].d, d_sign, d_inf, d_zero, longint'(d_scale), 64'(d_frac));
                        if (r_rtr) void'(dq.pop_front());
                    end
                end
                if (r_rts && c_rtr_o) begin
                    it.tag = c_tag_i;
                    it.d   = ref_decode(64'(c_word), 8, 0);
                    cq.push_back(it);
                    c_sent++;
                end
                if (r_rts && d_rtr_o) begin
                    it.tag = d_tag_i;
                    it.d   = ref_decode(64'(d_word), 32, 2);
                    dq.push_back(it);
                    d_sent++;
                end
                tick;
                cyc++;
            end
            check("rand.c_sent", 64'(c_sent), 64'(NW));
            check("rand.d_sent", 64'(d_sent), 64'(NW));
            check("rand.c_left", 64'(cq.size()), 64'd0);
            check("rand.d_left", 64'(dq.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
